// File: rtl/mdu_multicycle_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
// No latency of its own; stall_req is the only backpressure path toward the pipeline.
interface mdu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, rs, rt,
        input  busy, stall_req, hi, lo, done, div_zero
    );

    modport slave (
        input  start, op, rs, rt,
        output busy, stall_req, hi, lo, done, div_zero
    );
endinterface

// File: rtl/mdu_multicycle.sv
// HI/LO multiply/divide unit: MULT/MULTU/MADD/MSUB/DIV/DIVU plus MTHI/MTLO.
// Latency MULT_CYCLES or DIV_CYCLES busy cycles, MTHI/MTLO immediate; starts while busy are dropped, stall_req holds the pipeline.
module mdu_multicycle #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mdu_multicycle_if.slave mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             busy;
    op_e              op_in;
    logic             is_div_q;
    logic             b_zero;
    logic             div_ovf;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] res;

    logic [WIDTH-1:0]        b_udiv;
    logic [WIDTH-1:0]        b_sdiv;
    logic signed [WIDTH-1:0] a_sgn;
    logic signed [WIDTH-1:0] b_sgn;
    logic signed [WIDTH-1:0] quot_s;
    logic signed [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0]        quot_u;
    logic [WIDTH-1:0]        rem_u;

    assign busy     = (cnt_q != '0);
    assign op_in    = op_e'(mdu.op);
    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Operands are the registered copies, so the result is a pure function of
    // what was captured at acceptance plus the (frozen) HI/LO pair.
    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign acc    = {hi_q, lo_q};

    assign b_zero  = (b_q == '0);
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    // Substituting a divisor of 1 for min/-1 yields exactly quotient=min,
    // remainder=0; for rt==0 it just keeps the dividers out of undefined land.
    assign b_udiv = b_zero ? WIDTH'(1) : b_q;
    assign b_sdiv = (b_zero || div_ovf) ? WIDTH'(1) : b_q;

    assign a_sgn  = $signed(a_q);
    assign b_sgn  = $signed(b_sdiv);
    assign quot_s = a_sgn / b_sgn;
    assign rem_s  = a_sgn % b_sgn;
    assign quot_u = a_q / b_udiv;
    assign rem_u  = a_q % b_udiv;

    always_comb begin
        res = acc;
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_MADD:  res = acc + prod_s;
            OP_MSUB:  res = acc - prod_s;
            OP_DIV:   res = {rem_s, quot_s};
            OP_DIVU:  res = {rem_u, quot_u};
            default:  res = acc;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    case (op_in)
                        OP_MTHI: hi_d = mdu.rs;
                        OP_MTLO: lo_d = mdu.rs;
                        default: begin
                            op_d    = op_in;
                            a_d     = mdu.rs;
                            b_d     = mdu.rt;
                            cnt_d   = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? DIV_LOAD : MULT_LOAD;
                            state_d = S_BUSY;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    // Divide by zero leaves HI/LO untouched but still reports.
                    if (is_div_q && b_zero) begin
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = res[2*WIDTH-1:WIDTH];
                        lo_d = res[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign mdu.busy      = busy;
    assign mdu.stall_req = busy | (mdu.start & (mdu.op <= 3'd5));
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;
    assign mdu.done      = done_q;
    assign mdu.div_zero  = div_zero_q;

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU.
- Owns the HI/LO registers.
- Supports signed/unsigned mult/div, MADD/MSUB accumulation, and MTHI/MTLO writes.
- Multiply and divide latencies are configurable.
- Exports busy and a combinational stall request consumed by the hazard unit.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MSUB (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is an MDU op; operation is accepted when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- rs  input  WIDTH  operand A (dividend; source for MTHI/MTLO).
- rt  input  WIDTH  operand B (divisor).
- busy  output  1  multi-cycle operation in progress.
- stall_req  output  1  combinational: busy | (start & op<=5).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- done  output  1  one-cycle pulse after a multi-cycle result commits.
- div_zero  output  1  one-cycle pulse, coincident with done, when a DIV/DIVU had rt==0.

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Any pending result is discarded and no done is produced.
- Acceptance:
  - Occurs on a rising edge with start=1 and busy=0.
  - rs, rt and op are captured into internal registers; later changes on rs/rt have no effect.
- MTHI/MTLO:
  - Write hi (resp. lo) with rs at the accepting edge.
  - busy stays 0 and no done is produced.
- Multi-cycle ops:
  - At acceptance, counter loads MULT_CYCLES or DIV_CYCLES and busy=(counter!=0). busy is therefore high for exactly that many cycles, starting the cycle after acceptance.
  - hi/lo update at the edge where counter goes 1->0. busy falls on that same edge.
  - done (and div_zero, if applicable) is high for the one following cycle.
  - hi/lo hold their old values for the whole busy period.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not occur; the bench checks it anyway.
- Back-to-back: a new start is accepted in the cycle done is high, since busy=0 then.
- Arithmetic (all modulo 2^(2*WIDTH)):
  - MULT: {hi,lo}=signed rs*rt.
  - MULTU: {hi,lo}=unsigned product.
  - MADD: {hi,lo}={hi,lo}+signed(rs*rt).
  - MSUB: {hi,lo}={hi,lo}-signed(rs*rt).
  - The {hi,lo} operand for MADD/MSUB is the value at the commit edge, which equals the value at acceptance because nothing else can write it while busy.
  - DIV: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (min / -1): lo=min, hi=0.
  - Divide by zero: hi/lo unchanged; busy still lasts DIV_CYCLES; div_zero pulses.
- The result may be computed combinationally at acceptance and held, or iteratively. Only the visible timing above is normative.

Test Plan (WIDTH=32, default latencies):
- MULT rs=0xFFFFFFFE, rt=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses one cycle. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 0xFFFFFFFF then MTHI 0 (busy never rises), then MADD 1,1 -> hi=1, lo=0. From hi=lo=0, MSUB 1,1 -> hi=lo=0xFFFFFFFF.
- Preload hi=0x1234, lo=0x5678, then DIV rt=0 -> after 10 busy cycles hi/lo unchanged; done and div_zero pulse together.
- Accept MULT 2*3; during busy, drive start with MTHI 0xAAAA and change rs/rt -> hi=0, lo=6. stall_req=1 in the start cycle and throughout busy.
- Assert reset asynchronously during busy cycle 3 of a DIV -> busy/hi/lo go 0 immediately, with no done afterwards. A new MULT accepted after reset completes normally in 5 cycles.
